gmt_cmd_scheduler: RTL

- Command queue and sequencer between the CPU command interface and matrix_unit_new.
- Buffers geometry commands (create, delete, translate, rotate, scale) in a FIFO.
- Issues one command at a time using the go/busy handshake, waiting for each to complete before the next.
- The CPU can post bursts without polling busy; the scheduler can also hold off issue while the clipper is reading video memory.

---
 rtl/gmt_cmd_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/gmt_cmd_scheduler.sv
// Command FIFO and go/busy sequencer feeding matrix_unit_new.
// Optional CLIP_HOLD_EN: hold issue while the clipper reads video memory.
module gmt_cmd_scheduler #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_vld,
    output logic                     cmd_rdy,
    input  logic [3:0]               cmd_op,
    input  logic [3:0]               cmd_code,
    input  logic [4:0]               cmd_num,
    input  logic [1:0]               cmd_type,
    input  logic [7:0]               cmd_color,
    input  logic [127:0]             cmd_v,
    input  logic                     flush,
    input  logic                     mat_busy,
    input  logic                     clip_reading,
    output logic                     go,
    output logic [3:0]               gmt_op,
    output logic [3:0]               gmt_code,
    output logic [4:0]               obj_num,
    output logic [1:0]               obj_type,
    output logic [7:0]               obj_color,
    output logic [127:0]             v_out,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     q_full,
    output logic                     q_empty,
    output logic                     idle,
    output logic                     ack_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned WW = 151;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    logic [WW-1:0]  r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    state_t         r_state;
    logic [TW-1:0]  r_tmo;
    logic           r_go;
    logic           r_ack_err;
    logic [3:0]     r_gmt_op;
    logic [3:0]     r_gmt_code;
    logic [4:0]     r_obj_num;
    logic [1:0]     r_obj_type;
    logic [7:0]     r_obj_color;
    logic [127:0]   r_v_out;

    logic           w_hold;
    logic           w_push;
    logic           w_pop;
    logic [WW-1:0]  w_wdata;

`ifdef CLIP_HOLD_EN
    assign w_hold = clip_reading;
`else
    logic w_unused_clip;
    assign w_hold        = 1'b0;
    assign w_unused_clip = clip_reading;
`endif

    assign q_full  = (r_count == CW'(DEPTH));
    assign q_empty = (r_count == '0);
    assign cmd_rdy = ~q_full;
    assign q_count = r_count;
    assign idle    = q_empty & (r_state == S_IDLE);

    assign go        = r_go;
    assign ack_err   = r_ack_err;
    assign gmt_op    = r_gmt_op;
    assign gmt_code  = r_gmt_code;
    assign obj_num   = r_obj_num;
    assign obj_type  = r_obj_type;
    assign obj_color = r_obj_color;
    assign v_out     = r_v_out;

    // flush outranks both the push and the pop of the same edge
    assign w_push  = cmd_vld & ~q_full & ~flush;
    assign w_pop   = (r_state == S_IDLE) & ~q_empty & ~mat_busy & ~w_hold & ~flush;
    assign w_wdata = {cmd_v, cmd_color, cmd_type, cmd_num, cmd_code, cmd_op};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Issue sequencer: one command in flight, fields held until the next pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_go        <= 1'b0;
            r_tmo       <= '0;
            r_ack_err   <= 1'b0;
            r_gmt_op    <= '0;
            r_gmt_code  <= '0;
            r_obj_num   <= '0;
            r_obj_type  <= '0;
            r_obj_color <= '0;
            r_v_out     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        {r_v_out, r_obj_color, r_obj_type, r_obj_num, r_gmt_code, r_gmt_op}
                            <= r_mem[r_rd_ptr];
                        r_go    <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_go    <= 1'b0;
                    r_tmo   <= '0;
                    r_state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (mat_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                        if (r_tmo == TW'(ACK_TIMEOUT - 1)) begin
                            r_ack_err <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (!mat_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
